// File: rtl/bp_pht.sv
// bp_pht: pattern-history-table branch predictor.
// A table of 2^IDX_W saturating CNT_W-bit counters indexed from the fetch PC.
// A sequential clear sweep initialises the table after reset and on flush, so
// the table itself carries no reset and can map onto a RAM.
// Optional feature macro: BP_GSHARE_EN (gshare index hash with a
// non-speculative global history register). Undefined = bimodal.
//
// Handshake: lookup is a combinational query (lk_valid_i only qualifies
// lk_taken_o). An update is accepted when upd_valid_i=1 in RUN with
// flush_i=0; acceptance is acknowledged by a one-cycle upd_done_o pulse on
// the following cycle. There is no back-pressure.
module bp_pht #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int GHR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    output logic             busy_o,
    input  logic             lk_valid_i,
    input  logic [PC_W-1:0]  lk_pc_i,
    output logic             lk_taken_o,
    output logic [IDX_W-1:0] lk_idx_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic             upd_pred_i,
    output logic             upd_done_o,
    output logic             upd_correct_o,
    output logic [GHR_W-1:0] ghr_o
);

    localparam int DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [CNT_W-1:0] table_q [DEPTH];
    logic             upd_done_q, upd_correct_q;

    logic             upd_accept;
    logic [IDX_W-1:0] base_idx;
    logic [IDX_W-1:0] lk_idx;
    logic [CNT_W-1:0] lk_cnt;
    logic [CNT_W-1:0] upd_cur;
    logic [CNT_W-1:0] upd_nxt;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_waddr;
    logic [CNT_W-1:0] tbl_wdata;
    logic [GHR_W-1:0] ghr_w;

    // Only the index bits of the PC are used; the rest are deliberately ignored.
    logic unused_lk_pc;
    assign unused_lk_pc = ^lk_pc_i;

    // Byte-offset bits are dropped so consecutive instructions hit distinct entries.
    assign base_idx   = lk_pc_i[IDX_W+1:2];
    assign upd_accept = upd_valid_i & (state_q == ST_RUN) & ~flush_i;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    // History shifts in resolved outcomes only; flush empties it.
    always_comb begin
        ghr_d = ghr_q;
        if (flush_i) begin
            ghr_d = '0;
        end else if (upd_accept) begin
            ghr_d = GHR_W'({ghr_q, upd_taken_i});
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lk_idx = base_idx ^ IDX_W'(ghr_q);
    assign ghr_w  = ghr_q;
`else
    assign lk_idx = base_idx;
    assign ghr_w  = '0;
`endif

    // Saturating counter step for the update port.
    always_comb begin
        upd_cur = table_q[upd_idx_i];
        upd_nxt = upd_cur;
        if (upd_taken_i) begin
            if (upd_cur != CNT_MAX) upd_nxt = upd_cur + CNT_W'(1);
        end else begin
            if (upd_cur != '0) upd_nxt = upd_cur - CNT_W'(1);
        end
    end

    // Single write port: the sweep owns it in CLEAR, updates own it in RUN.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = clr_ptr_q;
        tbl_wdata = CNT_INIT;
        if (!flush_i) begin
            if (state_q == ST_CLEAR) begin
                tbl_we = 1'b1;
            end else if (upd_accept) begin
                tbl_we    = 1'b1;
                tbl_waddr = upd_idx_i;
                tbl_wdata = upd_nxt;
            end
        end
    end

    // Counter table storage (no reset; contents come from the sweep).
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_q[tbl_waddr] <= tbl_wdata;
        end
    end

    // Clear/run sequencing; flush restarts the sweep from entry 0.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (flush_i) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
        end else if (state_q == ST_CLEAR) begin
            if (clr_ptr_q == PTR_LAST) begin
                state_d   = ST_RUN;
                clr_ptr_d = '0;
            end else begin
                clr_ptr_d = clr_ptr_q + IDX_W'(1);
            end
        end
    end

    // FSM state and sweep pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Registered acknowledge of accepted updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_done_q    <= 1'b0;
            upd_correct_q <= 1'b0;
        end else begin
            upd_done_q    <= upd_accept;
            upd_correct_q <= upd_accept & (upd_pred_i == upd_taken_i);
        end
    end

    // Lookup reads the pre-update table contents; no write bypass.
    assign lk_cnt        = table_q[lk_idx];
    assign lk_idx_o      = lk_idx;
    assign lk_taken_o    = lk_valid_i & (state_q == ST_RUN) & lk_cnt[CNT_W-1];
    assign busy_o        = (state_q == ST_CLEAR);
    assign upd_done_o    = upd_done_q;
    assign upd_correct_o = upd_correct_q;
    assign ghr_o         = ghr_w;

endmodule

// File: tb/tb_bp_pht.sv
// Bench for bp_pht: reference model is an array of integer counters plus a
// "sweep edges remaining" count; expected acknowledges go through exp_q.
module tb_bp_pht;

  localparam int PC_W  = 32;
  localparam int IDX_W = 6;
  localparam int CNT_W = 2;
  localparam int GHR_W = 4;
  localparam int DEPTH = 64;
  localparam int INIT  = 1;
  localparam int MAXV  = 3;
`ifdef BP_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush_i;
  logic             busy_o;
  logic             lk_valid_i;
  logic [PC_W-1:0]  lk_pc_i;
  logic             lk_taken_o;
  logic [IDX_W-1:0] lk_idx_o;
  logic             upd_valid_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_taken_i;
  logic             upd_pred_i;
  logic             upd_done_o;
  logic             upd_correct_o;
  logic [GHR_W-1:0] ghr_o;

  bp_pht #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .GHR_W(GHR_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .busy_o(busy_o),
    .lk_valid_i(lk_valid_i), .lk_pc_i(lk_pc_i), .lk_taken_o(lk_taken_o),
    .lk_idx_o(lk_idx_o), .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i),
    .upd_taken_i(upd_taken_i), .upd_pred_i(upd_pred_i),
    .upd_done_o(upd_done_o), .upd_correct_o(upd_correct_o), .ghr_o(ghr_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time limit expired");
    $fatal(1);
  end

  // reference model and scoreboard
  int         m_cnt [DEPTH];
  int         m_rem;
  int         m_ghr;
  logic [1:0] exp_q [$];
  int         checks;
  int         failures;
  logic       seen_busy, seen_taken, seen_done, seen_correct;
  logic [5:0] seen_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    return ((pc >> 2) ^ m_ghr) % DEPTH;
  endfunction

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic step(input logic fl, input logic lv, input logic [31:0] pc,
                      input logic uv, input logic [5:0] ui, input logic ut,
                      input logic up);
    logic [1:0] e;
    int         ei;
    logic       et;
    logic       acc;
    flush_i = fl; lk_valid_i = lv; lk_pc_i = pc;
    upd_valid_i = uv; upd_idx_i = ui; upd_taken_i = ut; upd_pred_i = up;
    #1;
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
    ei = m_index(pc);
    et = lv && (m_rem == 0) && (m_cnt[ei] >= 2);
    chk("busy", 32'(busy_o), 32'(m_rem != 0));
    chk("lk_idx", 32'(lk_idx_o), 32'(ei));
    chk("lk_taken", 32'(lk_taken_o), 32'(et));
    chk("upd_done", 32'(upd_done_o), 32'(e[1]));
    if (e[1]) chk("upd_correct", 32'(upd_correct_o), 32'(e[0]));
    chk("ghr", 32'(ghr_o), 32'(m_ghr));
    seen_busy = busy_o; seen_taken = lk_taken_o; seen_done = upd_done_o;
    seen_correct = upd_correct_o; seen_idx = lk_idx_o;
    @(posedge clk);
    acc = uv && (m_rem == 0) && !fl;
    exp_q.push_back({acc, acc && (up == ut)});
    if (fl) begin
      m_rem = DEPTH;
      m_ghr = 0;
    end else if (m_rem > 0) begin
      m_cnt[DEPTH - m_rem] = INIT;
      m_rem--;
    end else if (uv) begin
      if (ut) m_cnt[ui] = (m_cnt[ui] < MAXV) ? m_cnt[ui] + 1 : MAXV;
      else    m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
      if (GSHARE) m_ghr = ((m_ghr << 1) | int'(ut)) % 16;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; returns at a negedge with reset released.
  task automatic apply_reset();
    flush_i = 1'b0; upd_valid_i = 1'b0; lk_valid_i = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_lk_taken", 32'(lk_taken_o), 32'd0);
    chk("rst_upd_done", 32'(upd_done_o), 32'd0);
    chk("rst_upd_correct", 32'(upd_correct_o), 32'd0);
    chk("rst_ghr", 32'(ghr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_rem = DEPTH;
    m_ghr = 0;
    exp_q.delete();
    exp_q.push_back(2'b00);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      idle($urandom);
      if (!seen_busy) break;
      n++;
    end
  endtask

  typedef struct {
    logic taken;
    logic pred;
    logic exp_taken;
    logic exp_correct;
  } sat_vec_t;

  sat_vec_t sv [7];
  int       nb;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; flush_i = 1'b0; lk_valid_i = 1'b0; lk_pc_i = '0;
    upd_valid_i = 1'b0; upd_idx_i = '0; upd_taken_i = 1'b0; upd_pred_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_cnt[i] = 0;
    m_rem = DEPTH; m_ghr = 0;

    sv[0] = '{1'b1, 1'b0, 1'b1, 1'b0};  // 01 -> 10
    sv[1] = '{1'b1, 1'b1, 1'b1, 1'b1};  // 10 -> 11
    sv[2] = '{1'b1, 1'b1, 1'b1, 1'b1};  // 11 saturates
    sv[3] = '{1'b0, 1'b1, 1'b1, 1'b0};  // 11 -> 10
    sv[4] = '{1'b0, 1'b1, 1'b0, 1'b0};  // 10 -> 01
    sv[5] = '{1'b0, 1'b0, 1'b0, 1'b1};  // 01 -> 00
    sv[6] = '{1'b0, 1'b0, 1'b0, 1'b1};  // 00 saturates

    // reset and initial sweep
    apply_reset();
    count_busy(nb);
    chk("sweep_len_reset", 32'(nb), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 32'(i << 2), 1'b0, 6'd0, 1'b0, 1'b0);
      chk("post_clear_taken", 32'(seen_taken), 32'd0);
    end

    // flush at clr_ptr=30 with an update dropped during the sweep
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      if (k == 10) step(1'b0, 1'b1, $urandom, 1'b1, 6'd3, 1'b1, 1'b1);
      else idle($urandom);
      if (k == 11) begin
        chk("drop_done", 32'(seen_done), 32'd0);
        chk("drop_ghr", 32'(ghr_o), 32'd0);
      end
    end
    step(1'b1, 1'b1, $urandom, 1'b1, 6'd3, 1'b1, 1'b0);
    count_busy(nb);
    chk("sweep_len_flush", 32'(nb), 32'd64);

`ifndef BP_GSHARE_EN
    // saturation and correctness pulse at pc 0x100 (idx 0)
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 32'h100, 1'b1, 6'd0, sv[i].taken, sv[i].pred);
      step(1'b0, 1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b0);
      chk("sat_taken", 32'(seen_taken), 32'(sv[i].exp_taken));
      chk("sat_done", 32'(seen_done), 32'd1);
      chk("sat_correct", 32'(seen_correct), 32'(sv[i].exp_correct));
    end
    idle(32'h100);
    chk("no_upd_done", 32'(seen_done), 32'd0);

    // same-cycle lookup and update on idx 5: no bypass
    step(1'b0, 1'b1, 32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
    chk("hazard_same_cycle", 32'(seen_taken), 32'd0);
    step(1'b0, 1'b1, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("hazard_next_cycle", 32'(seen_taken), 32'd1);
`else
    // gshare history and index hash
    step(1'b0, 1'b0, 32'h0, 1'b1, 6'd7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 6'd7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 6'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 6'd7, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("gshare_ghr", 32'(ghr_o), 32'hd);
    chk("gshare_idx", 32'(seen_idx), 32'd13);
`endif

    // randomized traffic, occasional flush and one async reset
    for (int k = 0; k < 500; k++) begin
      logic [5:0] ui;
      if (k == 250) apply_reset();
      ui = ($urandom_range(0, 1) == 1) ? seen_idx : 6'($urandom_range(0, DEPTH - 1));
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), ui, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
